// File: rtl/store_align_unit.sv
// store_align_unit: store path between execute and the data-memory bus.
// Takes one store request at a time, moves the data into its byte lanes,
// builds the byte strobes and drives one registered bus beat (two when a
// store straddles a word boundary). Completion or fault is reported on a
// one-cycle response pulse.
//
// Build option: define MISALIGN_SPLIT_EN to split word-crossing stores into
// two beats. Without it, any store whose offset is not a multiple of its size
// is rejected with resp_fault=1 and no bus activity.
module store_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_data,
  input  logic [2:0]          req_funct3,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_wstrb,
  output logic                resp_valid,
  output logic                resp_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Zero every byte of d at or above the access size (1 << sz bytes).
  function automatic logic [XLEN-1:0] mask_data(input logic [XLEN-1:0] d,
                                                input logic [1:0]      sz);
    logic [XLEN-1:0] m;
    int              lim;
    lim = 1 << sz;
    m   = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < lim) m[8*i +: 8] = 8'hFF;
    end
    return d & m;
  endfunction

  // Place the masked data at byte offset off inside a double-width window.
  function automatic logic [2*XLEN-1:0] shift_data(input logic [XLEN-1:0] d,
                                                   input logic [OFFW-1:0] off);
    logic [2*XLEN-1:0] w;
    w = {{XLEN{1'b0}}, d};
    return w << {off, 3'b000};
  endfunction

  // Strobes for a (1 << sz)-byte access at byte offset off, double width.
  function automatic logic [2*NB-1:0] lane_strobes(input logic [1:0]      sz,
                                                   input logic [OFFW-1:0] off);
    logic [2*NB-1:0] s;
    int              lim;
    lim = 1 << sz;
    s   = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < lim) s[i] = 1'b1;
    end
    return s << off;
  endfunction

`ifndef MISALIGN_SPLIT_EN
  // True when the offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0]      sz,
                                      input logic [OFFW-1:0] off);
    logic [OFFW-1:0] low_mask;
    int              lim;
    lim      = 1 << sz;
    low_mask = OFFW'(lim - 1);
    return |(off & low_mask);
  endfunction
`endif

  // Registered state and outputs
  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]       bus_wstrb_q, bus_wstrb_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;

  // Request decode
  logic [OFFW-1:0]     req_off;
  logic [1:0]          req_sz;
  logic                req_illegal;
  logic                req_reject;
  logic [ADDR_W-1:0]   req_base;
  logic [XLEN-1:0]     req_masked;
  logic [XLEN-1:0]     req_lo_data;
  logic [NB-1:0]       req_lo_strb;

`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0]     req_hi_data;
  logic [NB-1:0]       req_hi_strb;
  logic [XLEN-1:0]     hi_data_q, hi_data_d;
  logic [NB-1:0]       hi_strb_q, hi_strb_d;
`endif

  assign req_ready  = req_ready_q;
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;

  // Decode the incoming request into lane-aligned data, strobes and legality.
  always_comb begin
    req_off     = req_addr[OFFW-1:0];
    req_sz      = req_funct3[1:0];
    req_illegal = req_funct3[2] || ((XLEN == 32) && (req_funct3[1:0] == 2'b11));
    req_base    = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    req_masked  = mask_data(req_data, req_sz);
    req_lo_data = XLEN'(shift_data(req_masked, req_off));
    req_lo_strb = NB'(lane_strobes(req_sz, req_off));
`ifdef MISALIGN_SPLIT_EN
    req_hi_data = XLEN'(shift_data(req_masked, req_off) >> XLEN);
    req_hi_strb = NB'(lane_strobes(req_sz, req_off) >> NB);
    req_reject  = req_illegal;
`else
    req_reject  = req_illegal || misaligned(req_sz, req_off);
`endif
  end

  // Next-state and next-output logic for the store sequencer.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    bus_valid_d  = bus_valid_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    hi_data_d    = hi_data_q;
    hi_strb_d    = hi_strb_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (req_reject) begin
            // Illegal or misaligned: report a fault, never touch the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            bus_valid_d = 1'b1;
            bus_addr_d  = req_base;
            bus_wdata_d = req_lo_data;
            bus_wstrb_d = req_lo_strb;
`ifdef MISALIGN_SPLIT_EN
            hi_data_d   = req_hi_data;
            hi_strb_d   = req_hi_strb;
`endif
          end
        end
      end

      BEAT0: begin
        if (bus_ready) begin
`ifdef MISALIGN_SPLIT_EN
          if (|hi_strb_q) begin
            // Second beat goes to the next word; the address wraps naturally.
            state_d     = BEAT1;
            bus_addr_d  = bus_addr_q + ADDR_W'(NB);
            bus_wdata_d = hi_data_q;
            bus_wstrb_d = hi_strb_q;
          end else begin
            state_d      = RESP;
            bus_valid_d  = 1'b0;
            resp_valid_d = 1'b1;
          end
`else
          state_d      = RESP;
          bus_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
`endif
        end
      end

`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        if (bus_ready) begin
          state_d      = RESP;
          bus_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
`endif

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // Register state and all outputs; reset returns to an idle, quiet bus.
  always_ff @(posedge clk) begin
`ifdef MISALIGN_SPLIT_EN
    hi_data_q <= hi_data_d;
    hi_strb_q <= hi_strb_d;
`endif
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      bus_valid_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      bus_valid_q  <= bus_valid_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
    end
  end

endmodule
